// File: rtl/idct_pair_reorder.sv
// idct_pair_reorder: ping-pong frame buffer ahead of the IDCT rotation stage.
// Replays each stored frame as pairs D(k), D((N-k) mod N).
module idct_pair_reorder #(
  parameter int wData   = 24,
  parameter int MAX_PTS = 2048,
  parameter int wAddr   = 11
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [wData-1:0] source_real_rev,
  output logic [wData-1:0] source_imag_rev,
  output logic [11:0]      fftpts_out
);

  typedef enum logic [1:0] {
    B_EMPTY, B_FILLING, B_FULL, B_DRAINING
  } bank_t;

  typedef enum logic [1:0] {
    W_IDLE, W_FILL, W_FLUSH
  } wst_t;

  typedef enum logic {
    R_IDLE, R_RUN
  } rdst_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [1:0]       err;
    logic [11:0]      n;
    logic [wData-1:0] re;
    logic [wData-1:0] im;
    logic [wData-1:0] rre;
    logic [wData-1:0] rim;
  } beat_t;

  function automatic logic pts_ok(input logic [11:0] n);
    return (n >= 12'd8) && (n <= 12'(MAX_PTS)) &&
           ((n & (n - 12'd1)) == 12'd0);
  endfunction

  logic [2*wData-1:0] mem [2][MAX_PTS];
  bank_t              bank_st  [2];
  logic [11:0]        bank_n   [2];
  logic [1:0]         bank_err [2];

  wst_t             w_state, w_nxt;
  logic             wbank;
  logic [wAddr-1:0] cnt, cnt_nxt, w_addr, n_last;
  logic [11:0]      n_lat, n_nxt;
  logic [1:0]       err, err_nxt;
  logic             keep, keep_nxt;
  logic             acc, w_we, in_ok;
  logic             set_fill, set_full, set_empty;

  rdst_t            r_state, r_nxt;
  logic             rbank, rbank_nxt;
  logic [wAddr-1:0] k, k_nxt, kb, r_last;
  logic [11:0]      r_n;
  logic [1:0]       r_err;
  logic             start, space, issue, last;
  logic             set_drain, free, drain_other;

  logic             rd_v, rd_sop, rd_eop;
  logic [1:0]       rd_err;
  logic [11:0]      rd_n;
  logic [2*wData-1:0] ra, rb;

  beat_t            ent0, ent1, ent2, b_in;
  logic [1:0]       q_cnt, wr_idx;
  logic [2:0]       occ;
  logic             push, pop;

  assign sink_ready = rst_n_sync &&
    (w_state != W_IDLE || bank_st[wbank] == B_EMPTY);
  assign acc    = sink_valid && sink_ready;
  assign in_ok  = pts_ok(fftpts_in);
  assign n_last = wAddr'(n_lat - 12'd1);

  always_comb begin
    w_nxt     = w_state;
    cnt_nxt   = cnt;
    n_nxt     = n_lat;
    err_nxt   = err;
    keep_nxt  = keep;
    w_we      = 1'b0;
    w_addr    = cnt;
    set_fill  = 1'b0;
    set_full  = 1'b0;
    set_empty = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (acc && sink_sop) begin
          w_we    = 1'b1;
          w_addr  = '0;
          n_nxt   = fftpts_in;
          err_nxt = sink_error;
          cnt_nxt = wAddr'(1);
          if (!sink_eop) begin
            set_fill = 1'b1;
            keep_nxt = 1'b0;
            w_nxt    = in_ok ? W_FILL : W_FLUSH;
          end
        end
      end
      W_FILL: begin
        if (acc) begin
          w_we = 1'b1;
          if (sink_sop) begin
            w_addr  = '0;
            n_nxt   = fftpts_in;
            err_nxt = sink_error;
            cnt_nxt = wAddr'(1);
            if (sink_eop) begin
              set_empty = 1'b1;
              w_nxt     = W_IDLE;
            end else if (!in_ok) begin
              keep_nxt = 1'b0;
              w_nxt    = W_FLUSH;
            end
          end else begin
            err_nxt = err | sink_error;
            if (sink_eop) begin
              w_nxt     = W_IDLE;
              set_full  = (cnt == n_last);
              set_empty = (cnt != n_last);
            end else if (cnt == n_last) begin
              // overlong frame: keep the first N beats, flag it
              err_nxt  = err | sink_error | 2'b01;
              keep_nxt = 1'b1;
              w_nxt    = W_FLUSH;
            end else begin
              cnt_nxt = cnt + wAddr'(1);
            end
          end
        end
      end
      W_FLUSH: begin
        if (acc && sink_eop) begin
          w_nxt     = W_IDLE;
          set_full  = keep;
          set_empty = !keep;
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  assign r_n    = bank_n[rbank];
  assign r_err  = bank_err[rbank];
  assign r_last = wAddr'(r_n - 12'd1);
  assign kb     = wAddr'((r_n - {1'b0, k}) & (r_n - 12'd1));
  assign occ    = {1'b0, q_cnt} + {2'b00, rd_v};
  assign space  = occ < 3'd3;
  assign start  = (r_state == R_IDLE) && (bank_st[rbank] == B_FULL);
  assign issue  = ((r_state == R_RUN) || start) && space;
  assign last   = issue && (k == r_last);

  always_comb begin
    r_nxt       = r_state;
    k_nxt       = k;
    rbank_nxt   = rbank;
    set_drain   = 1'b0;
    free        = 1'b0;
    drain_other = 1'b0;
    if (start) begin
      r_nxt     = R_RUN;
      set_drain = 1'b1;
    end
    if (issue) begin
      k_nxt = k + wAddr'(1);
      if (last) begin
        k_nxt     = '0;
        free      = 1'b1;
        rbank_nxt = ~rbank;
        if (bank_st[~rbank] == B_FULL) begin
          r_nxt       = R_RUN;
          drain_other = 1'b1;
        end else begin
          r_nxt = R_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      w_state <= W_IDLE;
      wbank   <= 1'b0;
      cnt     <= '0;
      n_lat   <= '0;
      err     <= '0;
      keep    <= 1'b0;
      r_state <= R_IDLE;
      rbank   <= 1'b0;
      k       <= '0;
      for (int i = 0; i < 2; i++) begin
        bank_st[i]  <= B_EMPTY;
        bank_n[i]   <= '0;
        bank_err[i] <= '0;
      end
    end else begin
      w_state <= w_nxt;
      cnt     <= cnt_nxt;
      n_lat   <= n_nxt;
      err     <= err_nxt;
      keep    <= keep_nxt;
      r_state <= r_nxt;
      rbank   <= rbank_nxt;
      k       <= k_nxt;
      // read and write sides never touch the same bank in one cycle
      if (set_drain)   bank_st[rbank]  <= B_DRAINING;
      if (free)        bank_st[rbank]  <= B_EMPTY;
      if (drain_other) bank_st[~rbank] <= B_DRAINING;
      if (set_fill)    bank_st[wbank]  <= B_FILLING;
      if (set_empty)   bank_st[wbank]  <= B_EMPTY;
      if (set_full) begin
        bank_st[wbank]  <= B_FULL;
        bank_n[wbank]   <= n_lat;
        bank_err[wbank] <= err_nxt;
        wbank           <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) mem[wbank][w_addr] <= {sink_real, sink_imag};
    ra <= mem[rbank][k];
    rb <= mem[rbank][kb];
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rd_v   <= 1'b0;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      rd_err <= '0;
      rd_n   <= '0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        rd_sop <= (k == '0);
        rd_eop <= last;
        rd_err <= r_err;
        rd_n   <= r_n;
      end
    end
  end

  always_comb begin
    b_in     = '0;
    b_in.sop = rd_sop;
    b_in.eop = rd_eop;
    b_in.err = rd_err;
    b_in.n   = rd_n;
    b_in.re  = ra[2*wData-1:wData];
    b_in.im  = ra[wData-1:0];
    b_in.rre = rb[2*wData-1:wData];
    b_in.rim = rb[wData-1:0];
  end

  assign push   = rd_v;
  assign pop    = source_valid && source_ready;
  assign wr_idx = q_cnt - {1'b0, pop};

  // ent0 is the output register, ent1/ent2 the skid slots
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      ent0  <= '0;
      ent1  <= '0;
      ent2  <= '0;
      q_cnt <= '0;
    end else begin
      if (push && wr_idx == 2'd0) ent0 <= b_in;
      else if (pop)               ent0 <= ent1;
      if (push && wr_idx == 2'd1) ent1 <= b_in;
      else if (pop)               ent1 <= ent2;
      if (push && wr_idx == 2'd2) ent2 <= b_in;
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign source_valid    = (q_cnt != 2'd0);
  assign source_sop      = ent0.sop;
  assign source_eop      = ent0.eop;
  assign source_error    = ent0.err;
  assign fftpts_out      = ent0.n;
  assign source_real     = ent0.re;
  assign source_imag     = ent0.im;
  assign source_real_rev = ent0.rre;
  assign source_imag_rev = ent0.rim;

endmodule

// File: tb/tb_idct_pair_reorder.sv
// tb_idct_pair_reorder: directed frames with a queue of expected beats.
// Checks pairing, framing, errors, stalls, latency and reset.
module tb_idct_pair_reorder;

  typedef struct {
    logic [23:0] re, im, rre, rim;
    logic        sop, eop;
    logic [1:0]  err;
    logic [11:0] n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_sync = 1'b0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic [1:0]  sink_error = '0;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] sink_real = '0;
  logic [23:0] sink_imag = '0;
  logic [11:0] fftpts_in = '0;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic [1:0]  source_error;
  logic        source_sop, source_eop;
  logic [23:0] source_real, source_imag;
  logic [23:0] source_real_rev, source_imag_rev;
  logic [11:0] fftpts_out;

  idct_pair_reorder dut (
    .clk(clk), .rst_n_sync(rst_n_sync),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_error(sink_error), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real),
    .sink_imag(sink_imag), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_error(source_error), .source_sop(source_sop),
    .source_eop(source_eop), .source_real(source_real),
    .source_imag(source_imag),
    .source_real_rev(source_real_rev),
    .source_imag_rev(source_imag_rev),
    .fftpts_out(fftpts_out)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   n_out = 0;
  int   n_hold = 0;
  int   first_cyc = -1;
  int   last_cyc = 0;
  int   eop_cyc = 0;
  int   fv_cyc = 0;
  bit   lat_seen = 1'b1;
  bit   stall_mode = 1'b0;
  bit   hold_pend = 1'b0;
  int   ph = 0;
  logic [3:0] pat = 4'b1001;
  logic [127:0] prev_snap = '0;
  int   rev8 [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
  exp_t exp_q [$];
  exp_t cur;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] snap();
    return {15'd0, source_valid, source_sop, source_eop,
            source_error, fftpts_out, source_real, source_imag,
            source_real_rev, source_imag_rev};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      source_ready = pat[ph];
      ph = (ph + 1) % 4;
    end else begin
      source_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n_sync) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_hold++;
        check("hold", snap(), prev_snap);
      end
      if (source_valid && !lat_seen) begin
        lat_seen = 1'b1;
        fv_cyc = cyc;
      end
      if (source_valid && source_ready) begin
        n_out++;
        last_cyc = cyc;
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(1), 128'(0));
        end else begin
          cur = exp_q.pop_front();
          check("real", 128'(source_real), 128'(cur.re));
          check("imag", 128'(source_imag), 128'(cur.im));
          check("real_rev", 128'(source_real_rev), 128'(cur.rre));
          check("imag_rev", 128'(source_imag_rev), 128'(cur.rim));
          check("ctl",
                128'({source_sop, source_eop, source_error, fftpts_out}),
                128'({cur.sop, cur.eop, cur.err, cur.n}));
        end
      end
      hold_pend = source_valid && !source_ready;
      prev_snap = snap();
    end
  end

  task automatic put(input logic sop, input logic eop,
                     input logic [1:0] e, input int re,
                     input int im, input int n);
    int w = 0;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = e;
    sink_real  = 24'(re);
    sink_imag  = 24'(im);
    fftpts_in  = 12'(n);
    @(negedge clk);
    while (!sink_ready && w < 500) begin
      stalls++;
      w++;
      @(negedge clk);
    end
    if (!sink_ready) check("sink_ready_timeout", 128'(0), 128'(1));
    if (eop) eop_cyc = cyc;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic send(input int n, input int len, input int eop_at,
                      input int err_k, input logic [1:0] err_v,
                      input int base);
    for (int i = 0; i < len; i++)
      put(i == 0, i == eop_at, (i == err_k) ? err_v : 2'b00,
          base + i, base + 100 + i, n);
  endtask

  task automatic expect_frame(input int n, input int base,
                              input logic [1:0] e);
    exp_t x;
    int rv;
    for (int i = 0; i < n; i++) begin
      rv    = (n == 8) ? rev8[i] : (n - i) % n;
      x.re  = 24'(base + i);
      x.im  = 24'(base + 100 + i);
      x.rre = 24'(base + rv);
      x.rim = 24'(base + 100 + rv);
      x.sop = (i == 0);
      x.eop = (i == n - 1);
      x.err = e;
      x.n   = 12'(n);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      t++;
      @(negedge clk);
    end
    check("drain", 128'(exp_q.size()), 128'(0));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("rst_sink_ready", 128'(sink_ready), 128'(0));
    check("rst_outputs", snap(), 128'(0));
    @(posedge clk);
    #1 rst_n_sync = 1'b1;
    @(negedge clk);
    check("rel_sink_ready", 128'(sink_ready), 128'(1));
    check("rel_valid", 128'(source_valid), 128'(0));
    @(posedge clk);
    #1;

    // basic N=8 frame and first-beat latency
    expect_frame(8, 0, 2'b00);
    lat_seen = 1'b0;
    send(8, 8, 7, -1, 2'b00, 0);
    wait_drain();
    check("latency", 128'(fv_cyc - eop_cyc), 128'(3));

    // three back-to-back N=16 frames
    stalls = 0;
    n0 = n_out;
    first_cyc = -1;
    for (int f = 0; f < 3; f++) expect_frame(16, 1000 * (f + 1), 2'b00);
    for (int f = 0; f < 3; f++) send(16, 16, 15, -1, 2'b00, 1000 * (f + 1));
    wait_drain();
    check("b2b_no_stall", 128'(stalls), 128'(0));
    check("b2b_count", 128'(n_out - n0), 128'(48));
    check("b2b_contig", 128'(last_cyc - first_cyc), 128'(47));

    // downstream stalls 1,0,0,1
    stalls = 0;
    n_hold = 0;
    stall_mode = 1'b1;
    for (int f = 0; f < 3; f++) expect_frame(8, 4000 + 200 * f, 2'b00);
    for (int f = 0; f < 3; f++) send(8, 8, 7, -1, 2'b00, 4000 + 200 * f);
    wait_drain();
    stall_mode = 1'b0;
    check("stall_backpressure", 128'(stalls > 0), 128'(1));
    check("stall_hold_seen", 128'(n_hold > 0), 128'(1));

    // short frame dropped, good frame after it
    send(8, 5, 4, -1, 2'b00, 5000);
    expect_frame(8, 5200, 2'b00);
    send(8, 8, 7, -1, 2'b00, 5200);
    wait_drain();

    // long frame kept and flagged
    expect_frame(8, 5400, 2'b01);
    send(8, 11, 10, -1, 2'b00, 5400);
    wait_drain();

    // per-beat error spreads to the frame
    expect_frame(8, 5600, 2'b10);
    send(8, 8, 7, 3, 2'b10, 5600);
    wait_drain();

    // non power-of-two length is dropped
    n0 = n_out;
    send(12, 12, 11, -1, 2'b00, 5800);
    repeat (30) @(negedge clk);
    check("bad_n_silent", 128'(n_out - n0), 128'(0));
    expect_frame(8, 6000, 2'b00);
    send(8, 8, 7, -1, 2'b00, 6000);
    wait_drain();

    // reset while draining one bank and filling the other
    expect_frame(16, 6200, 2'b00);
    send(16, 16, 15, -1, 2'b00, 6200);
    send(16, 3, -1, -1, 2'b00, 6400);
    #1 rst_n_sync = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_outputs", snap(), 128'(0));
    check("midrst_sink_ready", 128'(sink_ready), 128'(0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n_sync = 1'b1;
    @(negedge clk);
    check("midrst_rel_ready", 128'(sink_ready), 128'(1));
    check("midrst_rel_valid", 128'(source_valid), 128'(0));
    @(posedge clk);
    #1;
    expect_frame(8, 7000, 2'b00);
    send(8, 8, 7, -1, 2'b00, 7000);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
